// File: rtl/nts_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// nts_dispatch_pkg
// Shared definitions for the NTS receive dispatcher.
//   WORD_W      : width of one MAC / packet-buffer word
//   MASK_W      : width of the per-byte valid mask of a word
//   wr_state_t  : write-side frame capture FSM states
// -----------------------------------------------------------------------------
package nts_dispatch_pkg;

   localparam int WORD_W = 64;
   localparam int MASK_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DROP  = 2'd2
   } wr_state_t;

endpackage

// File: rtl/nts_dispatcher_bank_ram.sv
// -----------------------------------------------------------------------------
// nts_dispatcher_bank_ram
// Simple dual-port packet buffer RAM holding both ping-pong banks. The address
// MSB selects the bank. One write port, one read port with a registered
// (1-cycle) read.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : {bank, word index} write address
//   wr_data  : word to store
//   rd_addr  : {bank, word index} read address
//   rd_data  : word at rd_addr, one cycle later
// -----------------------------------------------------------------------------
module nts_dispatcher_bank_ram
   import nts_dispatch_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
)
(
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH:0]   wr_addr,
   input  logic [WORD_W-1:0]     wr_data,
   input  logic [ADDR_WIDTH:0]   rd_addr,
   output logic [WORD_W-1:0]     rd_data
);

   logic [WORD_W-1:0] mem [0:(2**(ADDR_WIDTH+1))-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/nts_dispatcher.sv
// -----------------------------------------------------------------------------
// nts_dispatcher
// Captures Ethernet frames from the 10G MAC RX stream into a two-bank
// ping-pong buffer, drops bad / oversized / unbufferable frames, and hands
// complete good frames to nts_engine through a first-word-fall-through read
// interface.
// Ports:
//   i_areset                       : async reset, active high
//   i_clk                          : clock
//   i_rx_data_valid                : MAC byte-valid (0 = idle)
//   i_rx_data                      : MAC word, first byte in [63:56]
//   i_rx_good_frame                : frame ended OK (with or after last word)
//   i_rx_bad_frame                 : frame ended with error
//   o_dispatch_packet_available    : complete frame ready in the read bank
//   i_dispatch_packet_read_discard : release the read bank
//   o_dispatch_data_valid          : byte mask of the frame's last word
//   o_dispatch_fifo_empty          : current read word is the last one
//   i_dispatch_fifo_rd_en          : consume current word
//   o_dispatch_fifo_rd_data        : current word (FWFT)
//   o_dropped_frames               : wrapping count of dropped frames
// -----------------------------------------------------------------------------
module nts_dispatcher
   import nts_dispatch_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
)
(
   input  logic                i_areset,
   input  logic                i_clk,
   input  logic [MASK_W-1:0]   i_rx_data_valid,
   input  logic [WORD_W-1:0]   i_rx_data,
   input  logic                i_rx_good_frame,
   input  logic                i_rx_bad_frame,
   output logic                o_dispatch_packet_available,
   input  logic                i_dispatch_packet_read_discard,
   output logic [MASK_W-1:0]   o_dispatch_data_valid,
   output logic                o_dispatch_fifo_empty,
   input  logic                i_dispatch_fifo_rd_en,
   output logic [WORD_W-1:0]   o_dispatch_fifo_rd_data,
   output logic [31:0]         o_dropped_frames
);

   // Length counts words, so it needs one more bit than a word index.
   localparam int LEN_W = ADDR_WIDTH + 1;

   // Write side
   wr_state_t           state;
   wr_state_t           state_nxt;
   logic                wr_sel;
   logic [LEN_W-1:0]    wr_ptr;
   logic [LEN_W-1:0]    wr_ptr_nxt;
   logic [MASK_W-1:0]   last_mask;
   logic [MASK_W-1:0]   last_mask_nxt;
   logic                word_in;
   logic                overflow;
   logic                commit;
   logic [LEN_W-1:0]    commit_len;
   logic [MASK_W-1:0]   commit_mask;
   logic                drop_inc;
   logic                ram_we;
   logic [ADDR_WIDTH:0] ram_waddr;
   logic [31:0]         drop_cnt;

   // Per-bank descriptors
   logic [1:0]          bank_full;
   logic [LEN_W-1:0]    bank_len  [2];
   logic [MASK_W-1:0]   bank_mask [2];

   // Read side
   logic                rd_sel;
   logic                rd_sel_nxt;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr_nxt;
   logic [LEN_W-1:0]    rd_last_idx;
   logic                last_word;
   logic                discard;
   logic                advance;
   logic [ADDR_WIDTH:0] ram_raddr;
   logic [WORD_W-1:0]   ram_rdata_p1;
   logic                avail_vld_p1;
   logic                avail_vld_p2;

   // ---------------------------------------------------------------------------
   // Write FSM (combinational next state)
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt     = state;
      wr_ptr_nxt    = wr_ptr;
      last_mask_nxt = last_mask;
      ram_we        = 1'b0;
      ram_waddr     = {wr_sel, wr_ptr[ADDR_WIDTH-1:0]};
      commit        = 1'b0;
      commit_len    = wr_ptr;
      commit_mask   = last_mask;
      drop_inc      = 1'b0;
      word_in       = |i_rx_data_valid;
      overflow      = 1'b0;

      case (state)
         IDLE: begin
            if (word_in) begin
               if (!bank_full[wr_sel]) begin
                  ram_we        = 1'b1;
                  ram_waddr     = {wr_sel, {ADDR_WIDTH{1'b0}}};
                  wr_ptr_nxt    = LEN_W'(1);
                  last_mask_nxt = i_rx_data_valid;
                  if (i_rx_bad_frame) begin
                     drop_inc   = 1'b1;
                     wr_ptr_nxt = '0;
                  end else if (i_rx_good_frame) begin
                     // Single-word frame ends on its only word.
                     commit      = 1'b1;
                     commit_len  = LEN_W'(1);
                     commit_mask = i_rx_data_valid;
                     wr_ptr_nxt  = '0;
                  end else begin
                     state_nxt = WRITE;
                  end
               end else if (i_rx_good_frame || i_rx_bad_frame) begin
                  drop_inc = 1'b1;
               end else begin
                  state_nxt = DROP;
               end
            end
         end

         WRITE: begin
            // wr_ptr's top bit set means the bank already holds 2**ADDR_WIDTH words.
            overflow = word_in && wr_ptr[ADDR_WIDTH];
            if (word_in && !overflow) begin
               ram_we        = 1'b1;
               wr_ptr_nxt    = wr_ptr + LEN_W'(1);
               last_mask_nxt = i_rx_data_valid;
            end
            if (i_rx_bad_frame || (i_rx_good_frame && overflow)) begin
               drop_inc   = 1'b1;
               state_nxt  = IDLE;
               wr_ptr_nxt = '0;
            end else if (i_rx_good_frame) begin
               // A word arriving with the strobe is already folded into *_nxt.
               commit      = 1'b1;
               commit_len  = wr_ptr_nxt;
               commit_mask = last_mask_nxt;
               state_nxt   = IDLE;
               wr_ptr_nxt  = '0;
            end else if (overflow) begin
               state_nxt = DROP;
            end
         end

         DROP: begin
            wr_ptr_nxt = '0;
            if (i_rx_good_frame || i_rx_bad_frame) begin
               drop_inc  = 1'b1;
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Read pointer (combinational): the RAM is addressed with the next pointer
   // so its registered output already holds the word the pointer will show.
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_last_idx = bank_len[rd_sel] - LEN_W'(1);
      last_word   = ({1'b0, rd_ptr} == rd_last_idx);
      discard     = i_dispatch_packet_read_discard && avail_vld_p2;
      advance     = i_dispatch_fifo_rd_en && avail_vld_p2 && !last_word && !discard;
      rd_sel_nxt  = rd_sel ^ discard;
      if (discard) begin
         rd_ptr_nxt = '0;
      end else if (advance) begin
         rd_ptr_nxt = rd_ptr + ADDR_WIDTH'(1);
      end else begin
         rd_ptr_nxt = rd_ptr;
      end
      ram_raddr = {rd_sel_nxt, rd_ptr_nxt};
   end

   // ---------------------------------------------------------------------------
   // Control registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         wr_sel       <= 1'b0;
         bank_full    <= 2'b00;
         rd_sel       <= 1'b0;
         rd_ptr       <= '0;
         avail_vld_p1 <= 1'b0;
         avail_vld_p2 <= 1'b0;
         drop_cnt     <= '0;
      end else begin
         state  <= state_nxt;
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         rd_sel <= rd_sel_nxt;
         // The written bank is free and the read bank is full, so a
         // same-cycle commit and discard always touch different banks.
         if (commit) begin
            bank_full[wr_sel] <= 1'b1;
            wr_sel            <= ~wr_sel;
         end
         if (discard) begin
            bank_full[rd_sel] <= 1'b0;
         end
         if (drop_inc) begin
            drop_cnt <= drop_cnt + 32'd1;
         end
         // Availability trails the full flag by the RAM read latency.
         avail_vld_p1 <= bank_full[rd_sel] && !discard;
         avail_vld_p2 <= avail_vld_p1 && !discard;
      end
   end

   // ---------------------------------------------------------------------------
   // Data registers (no reset)
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      last_mask <= last_mask_nxt;
      if (commit) begin
         bank_len[wr_sel]  <= commit_len;
         bank_mask[wr_sel] <= commit_mask;
      end
   end

   nts_dispatcher_bank_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (i_clk),
      .wr_en   (ram_we),
      .wr_addr (ram_waddr),
      .wr_data (i_rx_data),
      .rd_addr (ram_raddr),
      .rd_data (ram_rdata_p1)
   );

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign o_dispatch_packet_available = avail_vld_p2;
   assign o_dispatch_data_valid       = avail_vld_p2 ? bank_mask[rd_sel] : '0;
   assign o_dispatch_fifo_rd_data     = avail_vld_p2 ? ram_rdata_p1 : '0;
   assign o_dispatch_fifo_empty       = avail_vld_p2 ? last_word : 1'b1;
   assign o_dropped_frames            = drop_cnt;

endmodule
